mem_stage_wb: RTL and testbench
===============================

# mem_stage_wb

Parametrised memory stage for the memory-to-memory pipeline. It registers the ALU result, selects the store data, and queues stores in a WB_DEPTH-entry write buffer. The buffer drains into a single-port, byte-addressed, big-endian data memory on cycles without a load. Loads are forwarded from the buffer, and one word address is mapped to the I/O port.

## Interface
Parameters:
- DATA_WIDTH, 16, word width; multiple of 8; BYTES = DATA_WIDTH/8
- ADDR_WIDTH, 16, byte-address width
- MEM_BYTES, 1024, memory depth in bytes; power of two
- WB_DEPTH, 4, write-buffer entries; power of two, at least 2
- IO_ADDR, 16'hFFFE, word address mapped to the I/O port

Ports:
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- writeMem  in  1  store request this cycle
- readMem  in  1  load request this cycle
- memWriteData  in  2  store-data select: 0 MWD0, 1 ALU register, 2 MWD2, 3 zero
- ALUoutput  in  DATA_WIDTH  ALU result, captured into the ALU register
- memAddr  in  ADDR_WIDTH  byte address of the load or store
- MWD0, MWD2  in  DATA_WIDTH  alternate store-data sources
- memOut  out  DATA_WIDTH  load data, combinational
- memStall  out  1  the pipeline must hold its stage inputs this cycle
- ioInput  in  DATA_WIDTH  value returned by loads from IO_ADDR
- ioOutput  out  DATA_WIDTH  last value stored to IO_ADDR

## Operation
- ALU register:
  - Loads ALUoutput every cycle unless memStall = 1, in which case it holds.
  - Store data is taken from the current register value (before this edge), selected by memWriteData.
- Memory addressing:
  - A word at address A occupies bytes A .. A+BYTES-1. Byte A holds the MSB (big-endian).
  - Every byte index is reduced modulo MEM_BYTES, so a word at MEM_BYTES-1 wraps to byte 0.
- Write buffer: circular FIFO of {addr, data}.
  - Enqueue: on writeMem = 1 when memStall = 0.
  - Drain: when readMem = 0 and the buffer is non-empty, the oldest entry is written at the edge.
  - Full case: enqueue into a full buffer is accepted if a drain happens in the same cycle.
- I/O:
  - Draining an entry whose addr = IO_ADDR updates ioOutput instead of memory.
  - A load from IO_ADDR returns ioInput. It never forwards and never stalls.
- Loads (combinational, same cycle):
  - The result reflects buffer and memory state before this cycle's enqueue.
  - If the youngest overlapping buffer entry has exactly memAddr, memOut = its data.
  - If any entry overlaps memAddr only partially, memStall = 1. The buffer drains during the stall cycles (drain is permitted even though readMem = 1 while stalled).
  - With no overlap, memOut = the memory read.
  - With readMem = 0, memOut = 0.
- memStall = 1 when either condition holds:
  - partial-overlap load conflict; or
  - writeMem = 1, the buffer is full, and no drain happens this cycle.
- memStall = 1 blocks enqueue. The stalled request is re-presented unchanged the next cycle.

## Timing
- Reset, at the first rising edge with reset = 0:
  - ALU register = 0, ioOutput = 0.
  - Buffer empty (head = tail = 0, count = 0).
  - memStall = 0 and memOut = 0, provided readMem = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all buffered stores. Those stores never reach memory or ioOutput.
- Store visibility:
  - In the cycle after it is accepted, the store is visible to loads through forwarding.
  - It reaches memory at the first following edge where it is the oldest entry and a drain happens.
- Load latency is 0 cycles: memOut is valid in the same cycle as readMem.
- Each stall lasts until the conflict clears. The conflict clears at the edge where the last overlapping entry drains.
- Pointer wrap: head and tail are log2(WB_DEPTH) bits and wrap naturally. count is log2(WB_DEPTH)+1 bits, ranging 0..WB_DEPTH.

## Configuration
- MEM_STAGE_FWD_EN defined:
  - Exact-address loads forward from the buffer as described in Operation.
- MEM_STAGE_FWD_EN undefined:
  - There is no forwarding. Any load overlapping any buffered entry, exact or partial, asserts memStall until every overlapping entry has drained; it then reads memory.
  - The forwarding comparator/priority logic is not built.

## Test plan
- Reset, then a single store and load:
  - Hold reset = 0 for 2 cycles, then release. Expect ioOutput = 0, memStall = 0, memOut = 0.
  - Store 16'hBEEF at 16'h0010 (memWriteData = 0), then idle one cycle. Expect byte 0x10 = 8'hBE and byte 0x11 = 8'hEF.
- Forwarding:
  - Store 16'h1234 at 16'h0020, then load 16'h0020 on the next 4 consecutive cycles.
  - With MEM_STAGE_FWD_EN: memOut = 16'h1234 on every load, memStall = 0, and the buffer drains only after readMem drops.
  - Without MEM_STAGE_FWD_EN: memStall = 1 for the first load, which holds while the entry drains. The load then reads memory and returns 16'h1234.
- Full buffer:
  - With readMem = 1 to a non-conflicting address, issue 5 stores (WB_DEPTH = 4). Expect the 5th to see memStall = 1.
  - Drop readMem. Expect the 5th store to be accepted in the same cycle the oldest entry drains.
- Partial overlap:
  - Buffer a store of 16'hAABB at 16'h0031, then load 16'h0030. Expect memStall = 1 until that entry drains, then memOut = {mem[0x30], 8'hAA}.
- I/O and wrap:
  - Store 16'h5A5A at IO_ADDR and drain. Expect ioOutput = 16'h5A5A and memory unchanged.
  - Load IO_ADDR with ioInput = 16'h0F0F. Expect memOut = 16'h0F0F.
  - Store 16'hC0DE at MEM_BYTES-1. Expect byte 1023 = 8'hC0 and byte 0 = 8'hDE.
- Reset mid-operation:
  - Buffer 3 stores with readMem held at 1, then pulse reset = 0 for 1 cycle. Expect the target bytes unchanged and ioOutput = 0 afterwards.

Source files
------------

// File: rtl/mem_stage_wb.sv
// mem_stage_wb: memory stage with ALU result register, store-data select and a
// WB_DEPTH-entry write buffer that drains into a big-endian byte memory on
// cycles without a load. One word address (IO_ADDR) maps to the I/O port.
// Optional feature macro: MEM_STAGE_FWD_EN enables exact-address forwarding
// from the buffer; without it any overlapping buffered store stalls the load.
module mem_stage_wb #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           MEM_BYTES  = 1024,
    parameter int unsigned           WB_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR    = 16'hFFFE
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  writeMem,
    input  logic                  readMem,
    input  logic [1:0]            memWriteData,
    input  logic [DATA_WIDTH-1:0] ALUoutput,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] MWD0,
    input  logic [DATA_WIDTH-1:0] MWD2,
    output logic [DATA_WIDTH-1:0] memOut,
    output logic                  memStall,
    input  logic [DATA_WIDTH-1:0] ioInput,
    output logic [DATA_WIDTH-1:0] ioOutput
);

    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
    localparam int unsigned PTR_W  = $clog2(WB_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [7:0]            r_mem     [MEM_BYTES];
    logic [ADDR_WIDTH-1:0] r_wb_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0] r_wb_data [WB_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_alu;
    logic [DATA_WIDTH-1:0] r_io;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_io_load;
    logic                  w_conflict;
    logic                  w_drain;
    logic                  w_enq;
    logic                  w_head_io;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [DATA_WIDTH-1:0] w_mem_rd;
    logic [MEM_AW-1:0]     w_diff [WB_DEPTH];
    logic [WB_DEPTH-1:0]   w_ovl;
`ifdef MEM_STAGE_FWD_EN
    logic [WB_DEPTH-1:0]   w_part;
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_fwd_data;
`endif

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(WB_DEPTH));
    assign w_head_io = (r_wb_addr[r_head] == IO_ADDR);
    assign ioOutput  = r_io;

    // Per-slot byte-range overlap with the load word; I/O entries never touch memory
    always_comb begin
        for (int unsigned j = 0; j < WB_DEPTH; j++) begin
            w_diff[j] = r_wb_addr[j][MEM_AW-1:0] - memAddr[MEM_AW-1:0];
            w_ovl[j]  = (r_wb_addr[j] != IO_ADDR) &&
                        ((32'(w_diff[j]) < BYTES) || (32'(w_diff[j]) > MEM_BYTES - BYTES));
`ifdef MEM_STAGE_FWD_EN
            w_part[j] = w_ovl[j] && (w_diff[j] != '0);
`endif
        end
    end

    // Scan valid entries oldest to youngest so the youngest overlapping entry decides
    always_comb begin
        w_io_load  = (memAddr == IO_ADDR);
        w_conflict = 1'b0;
`ifdef MEM_STAGE_FWD_EN
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
`endif
        for (int unsigned k = 0; k < WB_DEPTH; k++) begin
            if (readMem && !w_io_load && (CNT_W'(k) < r_count) &&
                w_ovl[r_head + PTR_W'(k)]) begin
`ifdef MEM_STAGE_FWD_EN
                if (w_part[r_head + PTR_W'(k)]) begin
                    w_conflict = 1'b1;
                end
                w_fwd_hit  = !w_part[r_head + PTR_W'(k)];
                w_fwd_data = r_wb_data[r_head + PTR_W'(k)];
`else
                w_conflict = 1'b1;
`endif
            end
        end
    end

    // A conflicting load lets the buffer drain so the conflict can clear
    assign w_drain  = !w_empty && (!readMem || w_conflict);
    assign memStall = w_conflict || (writeMem && w_full && !w_drain);
    assign w_enq    = writeMem && !memStall;

    // Store-data source select, using the ALU register value before this edge
    always_comb begin
        w_st_data = '0;
        case (memWriteData)
            2'd0:    w_st_data = MWD0;
            2'd1:    w_st_data = r_alu;
            2'd2:    w_st_data = MWD2;
            default: w_st_data = '0;
        endcase
    end

    // Big-endian word read with byte indices wrapping at the memory size
    always_comb begin
        w_mem_rd = '0;
        for (int unsigned k = 0; k < BYTES; k++) begin
            w_mem_rd[(BYTES-1-k)*8 +: 8] = r_mem[memAddr[MEM_AW-1:0] + MEM_AW'(k)];
        end
    end

    // Load result mux: I/O word, forwarded entry or memory; zero when idle or stalled
    always_comb begin
        memOut = '0;
        if (readMem && !w_conflict) begin
            if (w_io_load) begin
                memOut = ioInput;
`ifdef MEM_STAGE_FWD_EN
            end else if (w_fwd_hit) begin
                memOut = w_fwd_data;
`endif
            end else begin
                memOut = w_mem_rd;
            end
        end
    end

    // Buffer payload storage at the tail slot
    always_ff @(posedge CLK) begin
        if (reset && w_enq) begin
            r_wb_addr[r_tail] <= memAddr;
            r_wb_data[r_tail] <= w_st_data;
        end
    end

    // Drain the oldest entry into memory; contents are never reset
    always_ff @(posedge CLK) begin
        if (reset && w_drain && !w_head_io) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                r_mem[r_wb_addr[r_head][MEM_AW-1:0] + MEM_AW'(k)] <=
                    r_wb_data[r_head][(BYTES-1-k)*8 +: 8];
            end
        end
    end

    // Control state: ALU register, I/O output, FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_alu   <= '0;
            r_io    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (!memStall) begin
                r_alu <= ALUoutput;
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
                if (w_head_io) begin
                    r_io <= r_wb_data[r_head];
                end
            end
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_enq && !w_drain) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_enq && w_drain) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Self-checking bench for mem_stage_wb: a byte-array/queue model of the
// memory stage is compared with the DUT every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_mem_stage_wb;

    localparam int          MEMB = 1024;
    localparam int          WBD  = 4;
    localparam logic [15:0] IOA  = 16'hFFFE;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        writeMem = 1'b0;
    logic        readMem = 1'b0;
    logic [1:0]  memWriteData = 2'd0;
    logic [15:0] ALUoutput = '0;
    logic [15:0] memAddr = '0;
    logic [15:0] MWD0 = '0;
    logic [15:0] MWD2 = '0;
    logic [15:0] memOut;
    logic        memStall;
    logic [15:0] ioInput = '0;
    logic [15:0] ioOutput;

    mem_stage_wb #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .MEM_BYTES (MEMB),
        .WB_DEPTH  (WBD),
        .IO_ADDR   (IOA)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .writeMem    (writeMem),
        .readMem     (readMem),
        .memWriteData(memWriteData),
        .ALUoutput   (ALUoutput),
        .memAddr     (memAddr),
        .MWD0        (MWD0),
        .MWD2        (MWD2),
        .memOut      (memOut),
        .memStall    (memStall),
        .ioInput     (ioInput),
        .ioOutput    (ioOutput)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [7:0]  mem_m [MEMB];
    logic [15:0] q_addr [$];
    logic [15:0] q_data [$];
    logic [15:0] alu_m = '0;
    logic [15:0] io_m = '0;
    bit          model_valid = 1'b0;
    bit          e_iol, e_conflict, e_fwd, e_drain, e_stall;
    logic [15:0] e_fdata, e_out;
    bit          m_stall = 1'b0;
    bit          m_conf = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit overlaps(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if ((int'(a) + i) % MEMB == (int'(b) + j) % MEMB) return 1'b1;
        return 1'b0;
    endfunction

    // Expected outputs from the model state and the current inputs
    function automatic void evaluate();
        e_iol      = readMem && (memAddr == IOA);
        e_conflict = 1'b0;
        e_fwd      = 1'b0;
        e_fdata    = '0;
        if (readMem && !e_iol) begin
            for (int i = 0; i < q_addr.size(); i++) begin
                if (q_addr[i] != IOA && overlaps(q_addr[i], memAddr)) begin
`ifdef MEM_STAGE_FWD_EN
                    if (q_addr[i] == memAddr) begin
                        e_fwd   = 1'b1;
                        e_fdata = q_data[i];
                    end else begin
                        e_conflict = 1'b1;
                    end
`else
                    e_conflict = 1'b1;
`endif
                end
            end
        end
        e_drain = (q_addr.size() > 0) && (!readMem || e_conflict);
        e_stall = e_conflict || (writeMem && q_addr.size() == WBD && !e_drain);
        if (!readMem)   e_out = '0;
        else if (e_iol) e_out = ioInput;
        else if (e_fwd) e_out = e_fdata;
        else e_out = {mem_m[int'(memAddr) % MEMB], mem_m[(int'(memAddr) + 1) % MEMB]};
    endfunction

    // Compare process: outputs are sampled at the falling edge
    initial forever begin
        @(negedge CLK);
        if (model_valid) begin
            evaluate();
            m_stall = e_stall;
            m_conf  = e_conflict;
            chk("memStall", {15'b0, memStall}, {15'b0, e_stall});
            chk("ioOutput", ioOutput, io_m);
            if (!e_conflict) chk("memOut", memOut, e_out);
        end
    end

    // Model update at the rising edge
    initial forever begin
        logic [15:0] sd;
        @(posedge CLK);
        if (!reset) begin
            q_addr.delete();
            q_data.delete();
            alu_m       = '0;
            io_m        = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            evaluate();
            case (memWriteData)
                2'd0:    sd = MWD0;
                2'd1:    sd = alu_m;
                2'd2:    sd = MWD2;
                default: sd = '0;
            endcase
            if (e_drain) begin
                if (q_addr[0] == IOA) begin
                    io_m = q_data[0];
                end else begin
                    mem_m[int'(q_addr[0]) % MEMB]       = q_data[0][15:8];
                    mem_m[(int'(q_addr[0]) + 1) % MEMB] = q_data[0][7:0];
                end
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            if (writeMem && !e_stall) begin
                q_addr.push_back(memAddr);
                q_data.push_back(sd);
            end
            if (!e_stall) alu_m = ALUoutput;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit wm, input bit rm, input logic [1:0] sel,
                         input logic [15:0] addr, input logic [15:0] d0);
        writeMem     = wm;
        readMem      = rm;
        memWriteData = sel;
        memAddr      = addr;
        MWD0         = d0;
        MWD2         = 16'($urandom);
        ALUoutput    = 16'($urandom);
        ioInput      = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pre0, pre1;
        int          stall_run;
        int          r;

        // Reset held low for two edges
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_ioOutput", ioOutput, 16'h0000);
        chk("rst_memStall", {15'b0, memStall}, 16'h0000);
        chk("rst_memOut", memOut, 16'h0000);

        // Fill the whole memory so every later load has a known model value
        for (int a = 0; a < MEMB; a += 2) begin
            drive(1'b1, 1'b0, 2'd0, 16'(a), 16'($urandom));
            tick();
        end
        idle(2);

        // Single store then load
        drive(1'b1, 1'b0, 2'd0, 16'h0010, 16'hBEEF);
        tick();
        idle(1);
        drive(1'b0, 1'b1, 2'd0, 16'h0010, 16'h0000);
        #1 chk("beef_word", memOut, 16'hBEEF);
        tick();
        drive(1'b0, 1'b1, 2'd0, 16'h0011, 16'h0000);
        #1 chk("beef_byte11", {8'h00, memOut[15:8]}, 16'h00EF);
        tick();

        // Forwarding or stall-then-read on an exact-address load
        drive(1'b1, 1'b0, 2'd0, 16'h0020, 16'h1234);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'd0, 16'h0020, 16'h0000);
            #1;
`ifdef MEM_STAGE_FWD_EN
            chk("fwd_stall", {15'b0, memStall}, 16'h0000);
            chk("fwd_data", memOut, 16'h1234);
`else
            if (i == 0) begin
                chk("nofwd_stall", {15'b0, memStall}, 16'h0001);
            end else begin
                chk("nofwd_stall_clr", {15'b0, memStall}, 16'h0000);
                chk("nofwd_data", memOut, 16'h1234);
            end
`endif
            tick();
        end
        idle(2);

        // Full buffer while loads block draining
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'(i), 16'h0090 + 16'(2 * i), 16'($urandom));
            #1;
            chk("full_stall", {15'b0, memStall}, (i == 4) ? 16'h0001 : 16'h0000);
            if (i < 4) tick();
        end
        readMem = 1'b0;
        #1 chk("full_accept", {15'b0, memStall}, 16'h0000);
        tick();
        idle(5);

        // Partial overlap stall
        drive(1'b1, 1'b0, 2'd0, 16'h0031, 16'hAABB);
        tick();
        drive(1'b0, 1'b1, 2'd0, 16'h0030, 16'h0000);
        #1 chk("part_stall", {15'b0, memStall}, 16'h0001);
        tick();
        #1;
        chk("part_clear", {15'b0, memStall}, 16'h0000);
        chk("part_lo", {8'h00, memOut[7:0]}, 16'h00AA);
        tick();
        idle(1);

        // I/O port and address wrap
        drive(1'b1, 1'b0, 2'd0, IOA, 16'h5A5A);
        tick();
        idle(1);
        #1 chk("io_out", ioOutput, 16'h5A5A);
        drive(1'b0, 1'b1, 2'd0, IOA, 16'h0000);
        ioInput = 16'h0F0F;
        #1 chk("io_load", memOut, 16'h0F0F);
        tick();
        drive(1'b0, 1'b1, 2'd0, 16'h03FE, 16'h0000);
        tick();
        drive(1'b1, 1'b0, 2'd0, 16'h03FF, 16'hC0DE);
        tick();
        idle(1);
        drive(1'b0, 1'b1, 2'd0, 16'h03FF, 16'h0000);
        #1 chk("wrap_word", memOut, 16'hC0DE);
        tick();
        drive(1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000);
        #1 chk("wrap_byte0", {8'h00, memOut[15:8]}, 16'h00DE);
        tick();

        // Randomized traffic; stalled requests are re-presented unchanged
        stall_run = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!m_stall) begin
                stall_run = 0;
                r = $urandom_range(0, 9);
                if (r <= 6)      memAddr = 16'h0040 + 16'($urandom_range(0, 7));
                else if (r == 7) memAddr = IOA;
                else if (r == 8) memAddr = 16'h03FF;
                else             memAddr = 16'h0000;
                writeMem     = ($urandom_range(0, 99) < 50);
                readMem      = ($urandom_range(0, 99) < 55);
                memWriteData = 2'($urandom);
                ALUoutput    = 16'($urandom);
                MWD0         = 16'($urandom);
                MWD2         = 16'($urandom);
                ioInput      = 16'($urandom);
            end else begin
                stall_run++;
                if (!m_conf) readMem = 1'b0;
                if (stall_run > 12) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_bound: got %0d stalled cycles expected at most 12",
                             stall_run);
                    break;
                end
            end
            tick();
        end
        idle(6);

        // Reset in the middle of buffered stores discards them
        pre0 = {mem_m[16'h100], mem_m[16'h101]};
        pre1 = {mem_m[16'h104], mem_m[16'h105]};
        drive(1'b1, 1'b1, 2'd0, 16'h0100, 16'h1111);
        tick();
        drive(1'b1, 1'b1, 2'd0, 16'h0104, 16'h2222);
        tick();
        drive(1'b1, 1'b1, 2'd0, IOA, 16'h3333);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1 chk("midrst_io", ioOutput, 16'h0000);
        idle(2);
        drive(1'b0, 1'b1, 2'd0, 16'h0100, 16'h0000);
        #1 chk("midrst_mem100", memOut, pre0);
        tick();
        drive(1'b0, 1'b1, 2'd0, 16'h0104, 16'h0000);
        #1 chk("midrst_mem104", memOut, pre1);
        tick();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
